fft_iter_core: RTL and testbench

- Sequential, parametrised successor to the combinational recursive FFT.
- Accepts N complex Qm.n samples over a valid/ready stream and computes an in-place iterative radix-2 DIT FFT, one butterfly per clock.
- Streams the N bins out in natural order.
- Direction (forward/inverse) is selected per frame at run time, not by elaboration parameter.

---
 rtl/fft_pkg.sv | 38 +++
 rtl/fft_butterfly.sv | 40 ++++
 rtl/fft_iter_core.sv | 184 ++++++++++++++++++
 tb/tb_fft_iter_core.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and helpers for the iterative FFT core: Q-format constants,
// state encoding, the input sample struct, bit reversal and twiddle generation.
package fft_pkg;

    localparam int BIT_INT  = 8;
    localparam int BIT_FRAC = 8;
    localparam int W        = BIT_INT + BIT_FRAC;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        UNLOAD  = 2'd2
    } state_t;

    typedef struct packed {
        logic signed [W:0] re;
        logic signed [W:0] im;
    } sample_t;

    function automatic int unsigned bitrev(input int unsigned k, input int unsigned bits);
        int unsigned r;
        r = 32'd0;
        for (int unsigned i = 32'd0; i < bits; i++) begin
            r = (r << 1) | ((k >> i) & 32'd1);
        end
        return r;
    endfunction

    // cos/sin(2*pi*k/n) scaled by 2^frac, rounded to nearest; only evaluated on constants
    function automatic int twiddle(input int k, input int n, input int frac, input logic use_sin);
        real ang;
        real v;
        ang = 6.283185307179586 * real'(k) / real'(n);
        v   = use_sin ? $sin(ang) : $cos(ang);
        return int'(v * real'(32'd1 << frac));
    endfunction

endpackage

// File: rtl/fft_butterfly.sv
// Combinational radix-2 DIT butterfly: t = b*w with each real product rounded
// half-up, then a' = a + t and b' = a - t.
module fft_butterfly #(
    parameter int DW      = 21,
    parameter int TW_FRAC = 14
) (
    input  logic signed [DW-1:0]      a_re,
    input  logic signed [DW-1:0]      a_im,
    input  logic signed [DW-1:0]      b_re,
    input  logic signed [DW-1:0]      b_im,
    input  logic signed [TW_FRAC+1:0] w_re,
    input  logic signed [TW_FRAC+1:0] w_im,
    output logic signed [DW-1:0]      ap_re,
    output logic signed [DW-1:0]      ap_im,
    output logic signed [DW-1:0]      bp_re,
    output logic signed [DW-1:0]      bp_im
);

    localparam int PW = DW + TW_FRAC + 2;
    localparam logic signed [PW-1:0] HALF = {{(PW-TW_FRAC){1'b0}}, 1'b1, {(TW_FRAC-1){1'b0}}};

    function automatic logic signed [DW-1:0] rmul(input logic signed [DW-1:0] x,
                                                  input logic signed [TW_FRAC+1:0] w);
        logic signed [PW-1:0] p;
        p = x * w;
        p = p + HALF;
        return DW'(p >>> TW_FRAC);
    endfunction

    logic signed [DW-1:0] t_re_s;
    logic signed [DW-1:0] t_im_s;

    assign t_re_s = rmul(b_re, w_re) - rmul(b_im, w_im);
    assign t_im_s = rmul(b_re, w_im) + rmul(b_im, w_re);
    assign ap_re  = a_re + t_re_s;
    assign ap_im  = a_im + t_im_s;
    assign bp_re  = a_re - t_re_s;
    assign bp_im  = a_im - t_im_s;

endmodule

// File: rtl/fft_iter_core.sv
// Iterative in-place radix-2 DIT FFT/IFFT: streams N samples in, runs one
// butterfly per clock, streams N bins out in natural order.
module fft_iter_core
    import fft_pkg::*;
#(
    parameter int N       = 16,
    parameter int TW_FRAC = 14
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [W:0]        in_re,
    input  logic signed [W:0]        in_im,
    input  logic                     inverse,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [W+$clog2(N):0] out_re,
    output logic signed [W+$clog2(N):0] out_im,
    output logic                     out_last,
    output logic                     busy
);

    localparam int LOGN = $clog2(N);
    localparam int DW   = W + 1 + LOGN;
    localparam int TWW  = TW_FRAC + 2;
    localparam int HN   = N / 2;
    localparam int SW   = $clog2(LOGN) + 1;

    state_t state_r, state_s;
    logic [LOGN-1:0] cnt_r;
    logic [SW-1:0]   stage_r;
    logic            inv_r;
    logic            out_valid_r, out_last_r;
    logic signed [DW-1:0] out_re_r, out_im_r;
    logic signed [DW-1:0] mem_re_r [N];
    logic signed [DW-1:0] mem_im_r [N];
    logic signed [TWW-1:0] rom_cos_s [HN];
    logic signed [TWW-1:0] rom_sin_s [HN];

    sample_t in_s;
    logic in_fire_s, load_out_s, unload_done_s, comp_last_s;
    logic [LOGN-1:0] wr_addr_s, half_s, a_idx_s, b_idx_s;
    logic [LOGN-2:0] mask_s, j_s, tw_idx_s;
    logic signed [TWW-1:0] w_re_s, w_im_s;
    logic signed [DW-1:0] ap_re_s, ap_im_s, bp_re_s, bp_im_s;

    for (genvar i = 0; i < HN; i++) begin : g_rom
        assign rom_cos_s[i] = TWW'(twiddle(i, N, TW_FRAC, 1'b0));
        assign rom_sin_s[i] = TWW'(twiddle(i, N, TW_FRAC, 1'b1));
    end

    assign in_s          = '{re: in_re, im: in_im};
    assign in_fire_s     = in_valid && (state_r == LOAD);
    assign load_out_s    = (state_r == UNLOAD) && (!out_valid_r || out_ready) && !(out_valid_r && out_last_r);
    assign unload_done_s = (state_r == UNLOAD) && out_valid_r && out_ready && out_last_r;
    assign comp_last_s   = (cnt_r == LOGN'(HN - 1));
    assign wr_addr_s     = LOGN'(bitrev(32'(cnt_r), LOGN));

    // Stage s pairs a = group*2^(s+1)+m with b = a+2^s; twiddle index is m*N/2^(s+1)
    assign j_s      = cnt_r[LOGN-2:0];
    assign half_s   = {{(LOGN-1){1'b0}}, 1'b1} << stage_r;
    assign mask_s   = (LOGN-1)'(half_s - {{(LOGN-1){1'b0}}, 1'b1});
    assign a_idx_s  = {j_s & ~mask_s, 1'b0} | {1'b0, j_s & mask_s};
    assign b_idx_s  = a_idx_s | half_s;
    assign tw_idx_s = (j_s & mask_s) << (SW'(LOGN - 1) - stage_r);
    assign w_re_s   = rom_cos_s[tw_idx_s];
    assign w_im_s   = inv_r ? rom_sin_s[tw_idx_s] : -rom_sin_s[tw_idx_s];

    fft_butterfly #(.DW(DW), .TW_FRAC(TW_FRAC)) u_bfly (
        .a_re  (mem_re_r[a_idx_s]),
        .a_im  (mem_im_r[a_idx_s]),
        .b_re  (mem_re_r[b_idx_s]),
        .b_im  (mem_im_r[b_idx_s]),
        .w_re  (w_re_s),
        .w_im  (w_im_s),
        .ap_re (ap_re_s),
        .ap_im (ap_im_s),
        .bp_re (bp_re_s),
        .bp_im (bp_im_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= LOAD;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            LOAD: begin
                if (in_fire_s && (cnt_r == LOGN'(N - 1))) state_s = COMPUTE;
                else                                      state_s = LOAD;
            end
            COMPUTE: begin
                if (comp_last_s && (stage_r == SW'(LOGN - 1))) state_s = UNLOAD;
                else                                           state_s = COMPUTE;
            end
            UNLOAD: begin
                if (unload_done_s) state_s = LOAD;
                else               state_s = UNLOAD;
            end
            default: state_s = LOAD;
        endcase
    end

    // Sample/butterfly/bin counter, stage counter and per-frame direction latch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r   <= '0;
            stage_r <= '0;
            inv_r   <= 1'b0;
        end else begin
            case (state_r)
                LOAD: begin
                    if (in_fire_s) begin
                        cnt_r <= cnt_r + 1'b1;
                        if (cnt_r == '0) inv_r <= inverse;
                    end
                end
                COMPUTE: begin
                    if (comp_last_s) begin
                        cnt_r   <= '0;
                        stage_r <= (stage_r == SW'(LOGN - 1)) ? '0 : stage_r + 1'b1;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                UNLOAD: begin
                    if (unload_done_s)   cnt_r <= '0;
                    else if (load_out_s) cnt_r <= cnt_r + 1'b1;
                end
                default: begin
                    cnt_r   <= '0;
                    stage_r <= '0;
                end
            endcase
        end
    end

    // Sample memory: bit-reversed load, then in-place butterfly writes
    always_ff @(posedge clk) begin
        if (rst_n && in_fire_s) begin
            mem_re_r[wr_addr_s] <= {{LOGN{in_s.re[W]}}, in_s.re};
            mem_im_r[wr_addr_s] <= {{LOGN{in_s.im[W]}}, in_s.im};
        end else if (rst_n && (state_r == COMPUTE)) begin
            mem_re_r[a_idx_s] <= ap_re_s;
            mem_im_r[a_idx_s] <= ap_im_s;
            mem_re_r[b_idx_s] <= bp_re_s;
            mem_im_r[b_idx_s] <= bp_im_s;
        end
    end

    // Output register; inverse frames are divided by N here
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_re_r    <= '0;
            out_im_r    <= '0;
        end else if (unload_done_s) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else if (load_out_s) begin
            out_valid_r <= 1'b1;
            out_last_r  <= (cnt_r == LOGN'(N - 1));
            out_re_r    <= inv_r ? (mem_re_r[cnt_r] >>> LOGN) : mem_re_r[cnt_r];
            out_im_r    <= inv_r ? (mem_im_r[cnt_r] >>> LOGN) : mem_im_r[cnt_r];
        end
    end

    assign in_ready  = (state_r == LOAD);
    assign busy      = (state_r != LOAD);
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign out_re    = out_re_r;
    assign out_im    = out_im_r;

endmodule

// File: tb/tb_fft_iter_core.sv
// Self-checking bench for fft_iter_core: directed and random frames checked
// against a double-precision DFT/IDFT reference.
module tb_fft_iter_core;

    localparam int N    = 16;
    localparam int LOGN = 4;
    localparam int W    = 16;
    localparam int DW   = W + 1 + LOGN;
    localparam real PI  = 3.141592653589793;

    logic clk = 1'b0;
    logic rst_n, in_valid, in_ready, inverse, out_valid, out_ready, out_last, busy;
    logic signed [W:0]    in_re, in_im;
    logic signed [DW-1:0] out_re, out_im;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t_last = 0;
    int x_re [N];
    int x_im [N];
    int got_re [N];
    int got_im [N];
    int ramp_re [N];
    int ramp_im [N];
    real ref_re [N];
    real ref_im [N];

    fft_iter_core #(.N(N), .TW_FRAC(14)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .inverse   (inverse),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int idx, input longint obs, input longint expv, input int tol);
        n_checks++;
        if (obs > expv + tol || obs < expv - tol) begin
            n_errors++;
            $display("FAIL %s[%0d]: got %0d expected %0d (tol %0d)", tag, idx, obs, expv, tol);
        end
    endtask

    function automatic int rnd(input real v);
        return int'($floor(v + 0.5));
    endfunction

    // Direct O(N^2) transform of x_re/x_im; inverse includes the 1/N scale
    task automatic ref_dft(input bit inv);
        real sr, si, ang;
        for (int k = 0; k < N; k++) begin
            sr = 0.0;
            si = 0.0;
            for (int n = 0; n < N; n++) begin
                ang = (inv ? 2.0 : -2.0) * PI * real'(k * n) / real'(N);
                sr  = sr + real'(x_re[n]) * $cos(ang) - real'(x_im[n]) * $sin(ang);
                si  = si + real'(x_re[n]) * $sin(ang) + real'(x_im[n]) * $cos(ang);
            end
            ref_re[k] = inv ? sr / real'(N) : sr;
            ref_im[k] = inv ? si / real'(N) : si;
        end
    endtask

    task automatic send_frame(input bit inv, input int stall_at);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check("in_ready_wait", 0, in_ready, 1, 0);
        for (int k = 0; k < N; k++) begin
            if (k == stall_at) begin
                in_valid = 1'b0;
                repeat (3) begin @(posedge clk); #1; end
            end
            in_valid = 1'b1;
            in_re    = (W+1)'(x_re[k]);
            in_im    = (W+1)'(x_im[k]);
            inverse  = (k == 0) ? inv : ~inv;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        inverse  = 1'b0;
        t_last   = cyc;
    endtask

    task automatic recv_frame(input bit chk_lat, input int bp_at);
        int guard;
        check("busy_compute", 0, busy, 1, 0);
        check("in_ready_compute", 0, in_ready, 0, 0);
        guard = 0;
        while (!out_valid && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        check("out_valid_wait", 0, out_valid, 1, 0);
        if (chk_lat) check("latency", 0, cyc - t_last, 33, 0);
        for (int b = 0; b < N; b++) begin
            if (b == bp_at) begin
                check("bp_pre_re", b, out_re, rnd(ref_re[b]), 1);
                out_ready = 1'b0;
                repeat (5) begin @(posedge clk); #1; end
                check("bp_valid", b, out_valid, 1, 0);
                check("bp_hold_re", b, out_re, rnd(ref_re[b]), 1);
                check("bp_hold_im", b, out_im, rnd(ref_im[b]), 1);
                out_ready = 1'b1;
            end
            check("valid", b, out_valid, 1, 0);
            check("last", b, out_last, (b == N - 1) ? 1 : 0, 0);
            got_re[b] = int'(out_re);
            got_im[b] = int'(out_im);
            @(posedge clk); #1;
        end
        check("in_ready_after", 0, in_ready, 1, 0);
        check("out_valid_after", 0, out_valid, 0, 0);
    endtask

    task automatic compare_frame(input string tag, input int tol0, input int tol);
        for (int b = 0; b < N; b++) begin
            check({tag, "_re"}, b, got_re[b], rnd(ref_re[b]), (b == 0) ? tol0 : tol);
            check({tag, "_im"}, b, got_im[b], rnd(ref_im[b]), (b == 0) ? tol0 : tol);
        end
    endtask

    task automatic set_impulse();
        for (int k = 0; k < N; k++) begin
            x_re[k] = (k == 0) ? 256 : 0;
            x_im[k] = 0;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_re     = '0;
        in_im     = '0;
        inverse   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 0, in_ready, 1, 0);
        check("rst_out_valid", 0, out_valid, 0, 0);
        check("rst_out_last", 0, out_last, 0, 0);
        check("rst_busy", 0, busy, 0, 0);
        check("rst_out_re", 0, out_re, 0, 0);
        check("rst_out_im", 0, out_im, 0, 0);
        rst_n = 1'b1;

        // Impulse: flat spectrum of exactly 256, also the latency measurement
        set_impulse();
        ref_dft(1'b0);
        send_frame(1'b0, -1);
        recv_frame(1'b1, -1);
        compare_frame("impulse", 0, 0);

        // DC with an input stall and output backpressure at bin 7
        for (int k = 0; k < N; k++) begin
            x_re[k] = 256;
            x_im[k] = 0;
        end
        ref_dft(1'b0);
        send_frame(1'b0, 6);
        recv_frame(1'b0, 7);
        compare_frame("dc", 0, 1);

        // Ramp forward, then the spectrum fed back as an inverse frame
        for (int k = 0; k < N; k++) begin
            ramp_re[k] = k * 256;
            ramp_im[k] = (15 - k) * 256;
            x_re[k]    = ramp_re[k];
            x_im[k]    = ramp_im[k];
        end
        ref_dft(1'b0);
        send_frame(1'b0, -1);
        recv_frame(1'b1, -1);
        compare_frame("ramp", 0, 2);
        for (int k = 0; k < N; k++) begin
            x_re[k]   = got_re[k];
            x_im[k]   = got_im[k];
            ref_re[k] = real'(ramp_re[k]);
            ref_im[k] = real'(ramp_im[k]);
        end
        send_frame(1'b1, -1);
        recv_frame(1'b0, -1);
        compare_frame("roundtrip", 1, 1);

        // Random forward frames
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < N; k++) begin
                x_re[k] = int'($urandom_range(2047, 0)) - 1024;
                x_im[k] = int'($urandom_range(2047, 0)) - 1024;
            end
            ref_dft(1'b0);
            send_frame(1'b0, (f == 1) ? 3 : -1);
            recv_frame(1'b0, -1);
            compare_frame("rand_fwd", 4, 4);
        end

        // Random inverse frame
        for (int k = 0; k < N; k++) begin
            x_re[k] = int'($urandom_range(4095, 0)) - 2048;
            x_im[k] = int'($urandom_range(4095, 0)) - 2048;
        end
        ref_dft(1'b1);
        send_frame(1'b1, -1);
        recv_frame(1'b0, -1);
        compare_frame("rand_inv", 2, 2);

        // Reset mid-COMPUTE discards the frame; a fresh impulse still works
        for (int k = 0; k < N; k++) begin
            x_re[k] = int'($urandom_range(1023, 0)) - 512;
            x_im[k] = int'($urandom_range(1023, 0)) - 512;
        end
        send_frame(1'b0, -1);
        repeat (9) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_in_ready", 0, in_ready, 1, 0);
        check("mid_rst_busy", 0, busy, 0, 0);
        check("mid_rst_out_valid", 0, out_valid, 0, 0);
        rst_n = 1'b1;
        set_impulse();
        ref_dft(1'b0);
        send_frame(1'b0, -1);
        recv_frame(1'b1, -1);
        compare_frame("post_rst", 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
